// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch control: per-latch enable/stall/nop, PC enable, halt and a dmem watchdog.
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;
endpackage

// state  | meaning
// RUN    | normal issue, hazards resolved combinationally
// DWAIT  | data memory access outstanding, watchdog counting
// HALTED | halt retired, pipeline frozen until reset
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DWAIT_TIMEOUT = 255
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dREN_mem,
    input  logic        dWEN_mem,
    input  logic        dREN_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  rs_dec,
    input  logic [4:0]  rt_dec,
    input  logic        uses_rt_dec,
    input  logic        branch_taken_ex,
    input  logic        halt_mem,
    output pipe_state_t fd_state,
    output pipe_state_t de_state,
    output pipe_state_t em_state,
    output pipe_state_t mw_state,
    output logic        pc_en,
    output logic        halt,
    output logic        mem_timeout
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {RUN, DWAIT, HALTED} ctrl_state_t;

    localparam int WAIT_W = $clog2(DWAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DWAIT_TIMEOUT);

    ctrl_state_t       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              dmem_pend;
    logic              load_use;

    assign dmem_pend = (dREN_mem | dWEN_mem) & ~dhit;
    assign load_use  = dREN_ex && (rt_ex != 5'd0) &&
                       ((rt_ex == rs_dec) || (uses_rt_dec && (rt_ex == rt_dec)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            wait_cnt    <= '0;
            halt        <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            halt        <= halt | (state_nxt == HALTED);
            mem_timeout <= mem_timeout | (wait_cnt_nxt == WAIT_MAX);
        end
    end

    // A pending halt waits behind the data access; it retires with the dhit.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (dmem_pend)
                    state_nxt = DWAIT;
                else if (halt_mem)
                    state_nxt = HALTED;
            end
            DWAIT: begin
                if (dhit)
                    state_nxt = halt_mem ? HALTED : RUN;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        wait_cnt_nxt = '0;
        if (state == DWAIT && state_nxt == DWAIT)
            wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_comb begin
        pc_en    = 1'b1;
        fd_state = PIPE_ENABLE;
        de_state = PIPE_ENABLE;
        em_state = PIPE_ENABLE;
        mw_state = PIPE_ENABLE;
        if (!nRST) begin
            pc_en    = 1'b0;
            fd_state = PIPE_NOP;
            de_state = PIPE_NOP;
            em_state = PIPE_NOP;
            mw_state = PIPE_NOP;
        end else if (state == HALTED) begin
            pc_en    = 1'b0;
            fd_state = PIPE_STALL;
            de_state = PIPE_STALL;
            em_state = PIPE_STALL;
            mw_state = PIPE_STALL;
        end else if (dmem_pend) begin
            pc_en    = 1'b0;
            fd_state = PIPE_STALL;
            de_state = PIPE_STALL;
            em_state = PIPE_STALL;
            mw_state = PIPE_NOP;
        end else if (branch_taken_ex && ihit) begin
            fd_state = PIPE_NOP;
            de_state = PIPE_NOP;
        end else if (branch_taken_ex) begin
            // Hold the branch in EX until the redirected fetch lands.
            pc_en    = 1'b0;
            fd_state = PIPE_NOP;
            de_state = PIPE_STALL;
            em_state = PIPE_NOP;
        end else if (load_use) begin
            pc_en    = 1'b0;
            fd_state = PIPE_STALL;
            de_state = PIPE_NOP;
        end else if (!ihit) begin
            pc_en    = 1'b0;
            fd_state = PIPE_NOP;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic flush_take;
    assign flush_take = (state != HALTED) && !dmem_pend && branch_taken_ex && ihit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && state != HALTED)
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_take)
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, corner sequences, random run vs. a reference model.
// Follows HAZARD_PERF_COUNTERS_EN to connect and check the optional counters.
module tb_pipeline_hazard_ctrl;
    import cpu_types_pkg::*;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
    logic [4:0]  rt_ex, rs_dec, rt_dec;
    logic        uses_rt_dec, branch_taken_ex, halt_mem;
    pipe_state_t fd_state, de_state, em_state, mw_state;
    logic        pc_en, halt, mem_timeout;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.DWAIT_TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
        .rt_ex(rt_ex), .rs_dec(rs_dec), .rt_dec(rt_dec),
        .uses_rt_dec(uses_rt_dec), .branch_taken_ex(branch_taken_ex),
        .halt_mem(halt_mem),
        .fd_state(fd_state), .de_state(de_state), .em_state(em_state), .mw_state(mw_state),
        .pc_en(pc_en), .halt(halt), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    typedef struct packed {
        logic       ihit, dhit, dren_m, dwen_m, dren_ex;
        logic [4:0] rt_ex, rs_dec, rt_dec;
        logic       uses_rt, br, halt_mem;
    } stim_t;

    typedef struct packed {
        logic        pc_en;
        pipe_state_t fd, de, em, mw;
    } resp_t;

    typedef struct {
        string name;
        stim_t s;
        resp_t r;
    } vec_t;

    int total = 0;
    int bad   = 0;

    bit          m_halted, m_wait, m_tmo;
    int          m_run;
    logic [31:0] m_stall, m_flush;

    function automatic stim_t mk(logic ih, logic dh, logic drm, logic dwm, logic drx,
                                 logic [4:0] rtx, logic [4:0] rs, logic [4:0] rt,
                                 logic u, logic br, logic hm);
        stim_t s;
        s.ihit = ih; s.dhit = dh; s.dren_m = drm; s.dwen_m = dwm; s.dren_ex = drx;
        s.rt_ex = rtx; s.rs_dec = rs; s.rt_dec = rt; s.uses_rt = u; s.br = br; s.halt_mem = hm;
        return s;
    endfunction

    function automatic resp_t mr(logic pc, pipe_state_t fd, pipe_state_t de,
                                 pipe_state_t em, pipe_state_t mw);
        resp_t r;
        r.pc_en = pc; r.fd = fd; r.de = de; r.em = em; r.mw = mw;
        return r;
    endfunction

    // Spec priority list written out directly.
    function automatic resp_t model_out(stim_t s);
        bit pend = (s.dren_m || s.dwen_m) && !s.dhit;
        bit lu   = s.dren_ex && s.rt_ex != 0 &&
                   (s.rt_ex == s.rs_dec || (s.uses_rt && s.rt_ex == s.rt_dec));
        if (m_halted)         return mr(0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL);
        if (pend)             return mr(0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP);
        if (s.br && s.ihit)   return mr(1, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE);
        if (s.br)             return mr(0, PIPE_NOP, PIPE_STALL, PIPE_NOP, PIPE_ENABLE);
        if (lu)               return mr(0, PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE);
        if (!s.ihit)          return mr(0, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE);
        return mr(1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE);
    endfunction

    task automatic model_reset();
        m_halted = 0; m_wait = 0; m_tmo = 0; m_run = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_clock(stim_t s);
        resp_t e = model_out(s);
        bit pend = (s.dren_m || s.dwen_m) && !s.dhit;
        bit next_wait, go_halt;
        if (m_halted) return;
        if (!e.pc_en) m_stall = m_stall + 1;
        if (!pend && s.br && s.ihit) m_flush = m_flush + 1;
        next_wait = m_wait ? !s.dhit : pend;
        go_halt   = s.halt_mem && !next_wait;
        m_run     = (m_wait && next_wait) ? m_run + 1 : 0;
        if (m_run >= TMO) m_tmo = 1;
        m_wait    = next_wait;
        m_halted  = go_halt;
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(stim_t s);
        ihit = s.ihit; dhit = s.dhit; dREN_mem = s.dren_m; dWEN_mem = s.dwen_m;
        dREN_ex = s.dren_ex; rt_ex = s.rt_ex; rs_dec = s.rs_dec; rt_dec = s.rt_dec;
        uses_rt_dec = s.uses_rt; branch_taken_ex = s.br; halt_mem = s.halt_mem;
    endtask

    task automatic chk_resp(string nm, resp_t e);
        chk({nm, ".pc_en"}, int'(pc_en), int'(e.pc_en));
        chk({nm, ".fd"}, int'(fd_state), int'(e.fd));
        chk({nm, ".de"}, int'(de_state), int'(e.de));
        chk({nm, ".em"}, int'(em_state), int'(e.em));
        chk({nm, ".mw"}, int'(mw_state), int'(e.mw));
    endtask

    task automatic chk_regs(string nm);
        chk({nm, ".halt"}, int'(halt), int'(m_halted));
        chk({nm, ".mem_timeout"}, int'(mem_timeout), int'(m_tmo));
`ifdef HAZARD_PERF_COUNTERS_EN
        chk({nm, ".stall_cycles"}, int'(stall_cycles), int'(m_stall));
        chk({nm, ".flush_count"}, int'(flush_count), int'(m_flush));
`endif
    endtask

    task automatic apply(string nm, stim_t s, resp_t e);
        @(negedge CLK);
        nRST = 1'b1;
        drive(s);
        #1;
        chk_resp(nm, e);
        @(posedge CLK);
        model_clock(s);
        #1;
        chk_regs(nm);
    endtask

    // Leaves nRST low; the next apply releases it at a falling edge.
    task automatic do_reset(stim_t s);
        @(negedge CLK);
        nRST = 1'b0;
        drive(s);
        #1;
        chk_resp("reset", mr(0, PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP));
        chk("reset.halt", int'(halt), 0);
        chk("reset.mem_timeout", int'(mem_timeout), 0);
        model_reset();
        @(posedge CLK);
        #1;
        chk_regs("reset_held");
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s.ihit     = ($urandom_range(0, 3) != 0);
        s.dhit     = 1'($urandom_range(0, 1));
        s.dren_m   = ($urandom_range(0, 3) == 0);
        s.dwen_m   = ($urandom_range(0, 4) == 0);
        s.dren_ex  = ($urandom_range(0, 2) == 0);
        s.rt_ex    = 5'($urandom_range(0, 3));
        s.rs_dec   = 5'($urandom_range(0, 3));
        s.rt_dec   = 5'($urandom_range(0, 3));
        s.uses_rt  = 1'($urandom_range(0, 1));
        s.br       = ($urandom_range(0, 5) == 0);
        s.halt_mem = ($urandom_range(0, 149) == 0);
        return s;
    endfunction

    initial begin
        vec_t  tbl[$];
        stim_t idle, lu5, dw_miss, dr_miss;
        resp_t r_all_en, r_dstall, r_lu, r_stop;

        idle     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu5      = mk(1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0);
        dr_miss  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        dw_miss  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        r_all_en = mr(1, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE);
        r_dstall = mr(0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP);
        r_lu     = mr(0, PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE);
        r_stop   = mr(0, PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL);

        tbl.push_back('{"idle",       idle, r_all_en});
        tbl.push_back('{"imiss",      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                        mr(0, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE)});
        tbl.push_back('{"lu_rs",      lu5, r_lu});
        tbl.push_back('{"lu_rt",      mk(1, 0, 0, 0, 1, 7, 1, 7, 1, 0, 0), r_lu});
        tbl.push_back('{"rt_unused",  mk(1, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0), r_all_en});
        tbl.push_back('{"lu_r0",      mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), r_all_en});
        tbl.push_back('{"br_hit",     mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                        mr(1, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE)});
        tbl.push_back('{"br_miss",    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                        mr(0, PIPE_NOP, PIPE_STALL, PIPE_NOP, PIPE_ENABLE)});
        tbl.push_back('{"br_over_lu", mk(1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 0),
                        mr(1, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE)});
        tbl.push_back('{"lu_imiss",   mk(0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0), r_lu});
        tbl.push_back('{"dread_hit",  mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), r_all_en});
        tbl.push_back('{"dwr_over_br", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0), r_dstall});
        tbl.push_back('{"dwr_done",   mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), r_all_en});

        nRST = 1'b0;
        drive(idle);
        model_reset();
        do_reset(idle);

        foreach (tbl[i]) apply(tbl[i].name, tbl[i].s, tbl[i].r);

        // Release with ihit and no hazards: issue immediately.
        do_reset(idle);
        apply("first_cycle", idle, r_all_en);

        apply("lu_stall", lu5, r_lu);
        apply("lu_after", idle, r_all_en);
        apply("lu_zero", mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), r_all_en);

        // Two back-to-back 3-cycle waits; a counter that failed to clear would trip the watchdog.
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) apply("dwait", dr_miss, r_dstall);
            apply("dwait_done", mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), r_all_en);
        end
        chk("no_timeout", int'(mem_timeout), 0);

        do_reset(idle);
        for (int c = 0; c < 2; c++)
            apply("br_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                  mr(0, PIPE_NOP, PIPE_STALL, PIPE_NOP, PIPE_ENABLE));
        apply("br_go", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
              mr(1, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE));
`ifdef HAZARD_PERF_COUNTERS_EN
        chk("flush_one", int'(flush_count), 1);
        chk("stall_two", int'(stall_cycles), 2);
`endif

        apply("halt_wait", dw_miss, r_dstall);
        chk("halt_not_yet", int'(halt), 0);
        apply("halt_dhit", mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1), r_all_en);
        chk("halt_set", int'(halt), 1);
        apply("halted_br", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), r_stop);
        apply("halted_lu", lu5, r_stop);
        apply("halted_idle", idle, r_stop);
        chk("halt_sticky", int'(halt), 1);

        do_reset(idle);
        for (int c = 0; c < 4; c++) apply("tmo_run", dr_miss, r_dstall);
        chk("tmo_early", int'(mem_timeout), 0);
        apply("tmo_hit", dr_miss, r_dstall);
        chk("tmo_set", int'(mem_timeout), 1);
        apply("tmo_sat", dr_miss, r_dstall);
        apply("tmo_dhit", mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), r_all_en);
        chk("tmo_sticky", int'(mem_timeout), 1);
        apply("tmo_idle", idle, r_all_en);
        do_reset(idle);
        chk("tmo_cleared", int'(mem_timeout), 0);

        for (int n = 0; n < 3000; n++) begin
            stim_t s = rnd_stim();
            if ($urandom_range(0, 99) == 0)
                do_reset(s);
            else
                apply("rnd", s, model_out(s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
